instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - ifu_state_e   : 2-bit fetch FSM state encoding
//   - fetch_entry_t : one prefetch buffer entry {instruction word, address}
//   - IFU_RESET_PC  : default first fetch address after reset
//   - NOP_INST      : canonical RV32 NOP (addi x0, x0, 0)
//   - align_pc()    : clears the byte-offset bits of a fetch address
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no request pending, waiting for buffer room
        ST_REQ  = 2'd1,  // request presented, waiting for imem_req_ready
        ST_WAIT = 2'd2,  // request accepted, waiting for its response
        ST_DROP = 2'd3   // request accepted before a redirect; discard its response
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Prefetch buffer between the memory response path and the core.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push_i, push_data_i : write one entry (ignored when full unless popping)
//   pop_i             : remove the head entry (ignored when empty)
//   flush_i           : discard every entry; wins over push and pop
//   head_data_o       : entry at the head (meaningful only when !empty_o)
//   empty_o           : no entries buffered
//   count_o           : number of entries buffered, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o     = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count alone, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Sequential instruction prefetcher with a single outstanding memory request
// and a small prefetch buffer (fetch_fifo) in front of the core.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr     : fetch request channel (word aligned)
//   imem_resp_valid/data          : fetch response, one per accepted request
//   redirect_valid, redirect_pc   : one-cycle fetch restart (bits [1:0] ignored)
//   inst_valid/ready, inst, inst_pc : instruction channel to the core
// Parameters:
//   RESET_PC   : first fetch address after reset
//   FIFO_DEPTH : prefetch buffer entries (power of two, >= 2)
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    ifu_state_e       state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_addr_q;   // address of the request currently outstanding
    logic             req_valid_q;

    logic             req_fire;
    logic             resp_push;
    logic             inst_pop;
    logic             outstanding;
    logic [CNT_W-1:0] occupancy;
    logic             can_fetch;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // NOTE: every signal driven from always_comb is assigned on every path
    // (defaults first where branches exist), otherwise a latch is inferred.
    always_comb begin
        req_fire    = req_valid_q && imem_req_ready;
        outstanding = (state_q == ST_WAIT) || (state_q == ST_DROP);
        occupancy   = fifo_count + CNT_W'(outstanding);
        can_fetch   = (occupancy < DEPTH_CNT);
        // A redirect overrides both buffer operations in its cycle.
        resp_push   = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
        inst_pop    = !fifo_empty && inst_ready && !redirect_valid;
        push_entry  = '{data: imem_resp_data, pc: req_addr_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!redirect_valid && can_fetch) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (req_fire) begin
                        // If the memory took the request in the redirect cycle,
                        // a response is still coming and must be thrown away.
                        state_q     <= redirect_valid ? ST_DROP : ST_WAIT;
                        req_valid_q <= 1'b0;
                        req_addr_q  <= fetch_pc_q;
                    end else if (redirect_valid) begin
                        state_q     <= ST_IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        state_q <= imem_resp_valid ? ST_IDLE : ST_DROP;
                    end else if (imem_resp_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    // The stale response is swallowed here; a redirect arriving
                    // together with it has nothing left to wait for.
                    if (imem_resp_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase

            if (redirect_valid) begin
                fetch_pc_q <= align_pc(redirect_pc);
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;  // wraps modulo 2^32
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (resp_push),
        .push_data_i (push_entry),
        .pop_i       (inst_pop),
        .flush_i     (redirect_valid),
        .head_data_o (head_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = !fifo_empty;
    // Head contents are masked while empty so stale storage never shows.
    assign inst           = fifo_empty ? 32'h0 : head_entry.data;
    assign inst_pc        = fifo_empty ? 32'h0 : head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench: a memory model answering each accepted request after a
// chosen or random latency, and a stream model of the instruction sequence the
// core must observe (contiguous addresses from reset or the latest redirect).
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_sel;      // 0 = random 1..4, otherwise fixed latency

    // Stream model state
    logic [31:0] exp_pc;       // next instruction address the core must see
    logic [31:0] exp_fetch;    // next address the unit must request
    bit          prev_redirect;
    bit          prev_pending;
    logic [31:0] prev_addr;
    bit          last_req_hs;

    logic [31:0] pop_pcs[$];
    logic [31:0] req_addrs[$];
    int          resp_count;
    int          req_count;
    int          pop_total = 0;
    int          base;
    logic [31:0] tgt;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        mem_busy        = 1'b0;
        mem_wait        = 0;
        prev_redirect   = 1'b0;
        prev_pending    = 1'b0;
        last_req_hs     = 1'b0;
        resp_count      = 0;
        req_count       = 0;
        pop_pcs.delete();
        req_addrs.delete();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        rst       = 1'b0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        @(negedge clk);
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
    endtask

    // One clock cycle: drive inputs after the falling edge, check the settled
    // outputs, then account for what the next rising edge will transfer.
    task automatic cycle(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [31:0] target);
        bit resp_now;
        bit req_hs;
        bit pop;
        @(negedge clk);
        resp_now        = mem_busy && (mem_wait == 1);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? word_at(mem_addr) : $urandom();
        imem_req_ready  = rq_rdy;
        inst_ready      = in_rdy;
        redirect_valid  = redir;
        redirect_pc     = redir ? target : $urandom();
        #1;

        if (prev_redirect) check("flush_empty", 32'(inst_valid), 32'd0);
        if (prev_pending) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (inst_valid) begin
            check("head_pc", inst_pc, exp_pc);
            check("head_data", inst, word_at(exp_pc));
        end

        req_hs = imem_req_valid && rq_rdy;
        pop    = inst_valid && in_rdy;

        if (resp_now) begin
            mem_busy = 1'b0;
            resp_count++;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (req_hs) begin
            check("one_outstanding", 32'(mem_busy), 32'd0);
            check("fetch_addr", imem_req_addr, exp_fetch);
            mem_busy = 1'b1;
            mem_wait = (lat_sel == 0) ? int'($urandom_range(1, 4)) : lat_sel;
            mem_addr = imem_req_addr;
            req_addrs.push_back(imem_req_addr);
            req_count++;
        end
        last_req_hs = req_hs;

        if (redir) begin
            exp_pc    = {target[31:2], 2'b00};
            exp_fetch = {target[31:2], 2'b00};
        end else begin
            if (pop) begin
                pop_pcs.push_back(inst_pc);
                pop_total++;
                exp_pc = exp_pc + 32'd4;
            end
            if (req_hs) exp_fetch = exp_fetch + 32'd4;
        end

        prev_redirect = redir;
        prev_pending  = imem_req_valid && !rq_rdy && !redir;
        prev_addr     = imem_req_addr;
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        lat_sel         = 1;

        // Sequential fetch, latency 1, core always ready
        do_reset();
        lat_sel = 1;
        for (int i = 0; i < 40 && pop_pcs.size() < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_pop_count", 32'(pop_pcs.size()), 32'd3);
        if (pop_pcs.size() >= 3) begin
            check("t1_pc0", pop_pcs[0], 32'h8000_0000);
            check("t1_pc1", pop_pcs[1], 32'h8000_0004);
            check("t1_pc2", pop_pcs[2], 32'h8000_0008);
        end

        // Core stalled: buffer fills to depth and fetching stops
        do_reset();
        lat_sel = 1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_buffered", 32'(resp_count), 32'(FIFO_DEPTH));
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_outstanding", 32'(mem_busy), 32'd0);
        check("t2_inst_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t2_drained", 32'(pop_pcs.size()), 32'd2);
        if (pop_pcs.size() >= 2) begin
            check("t2_pc0", pop_pcs[0], 32'h8000_0000);
            check("t2_pc1", pop_pcs[1], 32'h8000_0004);
        end

        // Redirect while waiting for a latency-3 response
        do_reset();
        lat_sel = 3;
        for (int i = 0; i < 20 && !last_req_hs; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_req_taken", 32'(mem_busy), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0103);
        for (int i = 0; i < 40 && pop_pcs.size() < 1; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_pop_count", 32'(pop_pcs.size()), 32'd1);
        if (pop_pcs.size() >= 1) check("t3_first_pc", pop_pcs[0], 32'h8000_0100);

        // Redirect together with a response and a pop
        do_reset();
        lat_sel = 2;
        for (int i = 0; i < 40 && !(resp_count == 1 && mem_busy && mem_wait == 1); i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_resp_due", 32'(mem_busy && mem_wait == 1), 32'd1);
        check("t4_one_buffered", 32'(inst_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0040);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        base = req_count;
        for (int i = 0; i < 20 && req_count <= base; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_new_req", 32'(req_count), 32'(base + 1));
        if (req_count > base) check("t4_req_addr", req_addrs[base], 32'h8000_0040);

        // Memory back-pressure: address holds, a single fetch issued
        do_reset();
        lat_sel = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            check("t5_valid", 32'(imem_req_valid), 32'd1);
            check("t5_addr", imem_req_addr, RESET_PC);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_req_count", 32'(req_count), 32'd1);

        // Address wrap after redirect to the top word
        do_reset();
        lat_sel = 1;
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 30 && req_count < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("t6_req_count", 32'(req_count), 32'd2);
        if (req_count >= 2) begin
            check("t6_addr0", req_addrs[0], 32'hFFFF_FFFC);
            check("t6_addr1", req_addrs[1], 32'h0000_0000);
        end

        // Randomized traffic with a reset dropped into the middle
        do_reset();
        lat_sel   = 0;
        pop_total = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, tgt);
        end
        check("random_progress", 32'(pop_total > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
